// File: rtl/apb_req_bridge.sv
`default_nettype none
// ======================================================================
// apb_req_bridge: single-outstanding APB4 master fed by a valid/ready
// request channel, with optional access-phase timeout. Revision: 1.0
// ======================================================================
module apb_req_bridge #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0,
    parameter int StrbWidth     = (DataWidth + 7) / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [StrbWidth-1:0] req_strb_i,
    input  logic [2:0]           req_prot_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,

    output logic [AddrWidth-1:0] paddr_o,
    output logic [2:0]           pprot_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [StrbWidth-1:0] pstrb_o,
    input  logic                 pready_i,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pslverr_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam bit TO_EN    = (TimeoutCycles > 0);
    localparam int CNT_W    = TO_EN ? $clog2(TimeoutCycles + 1) : 1;
    localparam int TO_LAST  = TO_EN ? TimeoutCycles - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

    logic [1:0]           state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [AddrWidth-1:0] paddr_q,  paddr_d;
    logic [2:0]           pprot_q,  pprot_d;
    logic                 pwrite_q, pwrite_d;
    logic [DataWidth-1:0] pwdata_q, pwdata_d;
    logic [StrbWidth-1:0] pstrb_q,  pstrb_d;
    logic [DataWidth-1:0] rdata_q,  rdata_d;
    logic                 err_q,    err_d;
    logic                 tout_q,   tout_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pprot_d  = pprot_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tout_d   = tout_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pprot_d  = req_prot_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_strb_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is tested first so a completing slave beats the timeout
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    tout_d  = 1'b0;
                    state_d = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pprot_q  <= pprot_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tout_q;
    assign paddr_o       = paddr_q;
    assign pprot_o       = pprot_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_bridge.sv
`default_nettype none
// ======================================================================
// tb_apb_req_bridge: randomized self-checking bench, TimeoutCycles = 4.
// Revision: 1.0
// ======================================================================
module tb_apb_req_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [SW-1:0] req_strb_i;
    logic [2:0]    req_prot_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [DW-1:0] rsp_rdata_o;
    logic [AW-1:0] paddr_o;
    logic [2:0]    pprot_o;
    logic          psel_o, penable_o, pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i, pslverr_i;
    logic [DW-1:0] prdata_i;

    int total = 0;
    int bad   = 0;

    // request presented during an in-flight transfer when hold_next is set
    logic          nx_write;
    logic [AW-1:0] nx_addr;
    logic [DW-1:0] nx_wdata;
    logic [SW-1:0] nx_strb;
    logic [2:0]    nx_prot;

    always #5 clk = ~clk;

    apb_req_bridge #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_write_i  (req_write_i),
        .req_wdata_i  (req_wdata_i),
        .req_strb_i   (req_strb_i),
        .req_prot_i   (req_prot_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .paddr_o      (paddr_o),
        .pprot_o      (pprot_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .pready_i     (pready_i),
        .prdata_i     (prdata_i),
        .pslverr_i    (pslverr_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer: requester + slave model + expected-response model.
    // waits = number of ACCESS cycles the slave holds pready low before it
    // completes; anything >= TO means the slave never answers in time.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                        input logic [2:0] prot, input int waits,
                        input logic serr, input logic [DW-1:0] rd,
                        input int rdly, input logic hold_next);
        logic [DW-1:0] exp_rd;
        logic          exp_err, exp_to;
        int            acc_exp, lat_exp, cyc, acc;
        bit            ok;
        if (waits < TO) begin
            acc_exp = waits + 1;
            exp_to  = 1'b0;
            exp_err = serr;
            exp_rd  = wr ? '0 : rd;
        end else begin
            acc_exp = TO;
            exp_to  = 1'b1;
            exp_err = 1'b1;
            exp_rd  = '0;
        end
        lat_exp = 2 + acc_exp;

        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: got %b want 1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_strb_i  = strb;
        req_prot_i  = prot;
        step();
        if (hold_next) begin
            req_write_i = nx_write;
            req_addr_i  = nx_addr;
            req_wdata_i = nx_wdata;
            req_strb_i  = nx_strb;
            req_prot_i  = nx_prot;
        end else begin
            req_valid_i = 1'b0;
            req_write_i = 1'($urandom);
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            req_strb_i  = 4'($urandom);
            req_prot_i  = 3'($urandom);
        end

        cyc = 1;
        acc = 0;
        ok  = 1'b1;
        while (rsp_valid_o !== 1'b1 && cyc < 40) begin
            if (psel_o !== 1'b1 || penable_o !== (cyc > 1) || req_ready_o !== 1'b0 ||
                paddr_o !== addr || pwrite_o !== wr || pwdata_o !== wdata ||
                pstrb_o !== strb || pprot_o !== prot)
                ok = 1'b0;
            if (penable_o === 1'b1) begin
                acc++;
                pready_i  = (acc == waits + 1);
                prdata_i  = pready_i ? rd : $urandom;
                pslverr_i = pready_i ? serr : 1'($urandom);
            end else begin
                pready_i = 1'b0;
            end
            step();
            cyc++;
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;

        total++;
        if (rsp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL rsp_wait: rsp_valid got %b want 1 within 40 cycles", rsp_valid_o);
            return;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL apb_phase: got psel/penable/fields wrong want setup-then-stable-access");
        end
        total++;
        if (acc !== acc_exp) begin
            bad++;
            $display("FAIL access_cycles: got %0d want %0d", acc, acc_exp);
        end
        total++;
        if (cyc !== lat_exp) begin
            bad++;
            $display("FAIL latency: got %0d want %0d", cyc, lat_exp);
        end
        total++;
        if ({psel_o, penable_o, req_ready_o} !== 3'b000) begin
            bad++;
            $display("FAIL resp_bus: got sel/en/rdy=%b want 000", {psel_o, penable_o, req_ready_o});
        end
        total++;
        if (rsp_rdata_o !== exp_rd) begin
            bad++;
            $display("FAIL rsp_rdata: got %h want %h", rsp_rdata_o, exp_rd);
        end
        total++;
        if (rsp_err_o !== exp_err) begin
            bad++;
            $display("FAIL rsp_err: got %b want %b", rsp_err_o, exp_err);
        end
        total++;
        if (rsp_timeout_o !== exp_to) begin
            bad++;
            $display("FAIL rsp_timeout: got %b want %b", rsp_timeout_o, exp_to);
        end

        ok = 1'b1;
        for (int d = 0; d < rdly; d++) begin
            step();
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || psel_o !== 1'b0 ||
                rsp_rdata_o !== exp_rd || rsp_err_o !== exp_err || rsp_timeout_o !== exp_to)
                ok = 1'b0;
        end
        if (rdly > 0) begin
            total++;
            if (ok !== 1'b1) begin
                bad++;
                $display("FAIL rsp_hold: got unstable response over %0d stalled cycles want stable", rdly);
            end
        end

        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        total++;
        if ({rsp_valid_o, req_ready_o, psel_o} !== 3'b010) begin
            bad++;
            $display("FAIL post_handshake: got vld/rdy/sel=%b want 010", {rsp_valid_o, req_ready_o, psel_o});
        end
        total++;
        if (paddr_o !== addr || pwdata_o !== wdata) begin
            bad++;
            $display("FAIL apb_hold: got addr=%h wdata=%h want %h %h", paddr_o, pwdata_o, addr, wdata);
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        req_prot_i  = '0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        prdata_i    = '0;
        pslverr_i   = 1'b0;
        step();
        step();
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        total++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, paddr_o, pprot_o,
             psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero (paddr=%h pwdata=%h rdata=%h) want all 0",
                     paddr_o, pwdata_o, rsp_rdata_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_zero_wait_write();
        xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    endtask

    task automatic test_wait_read();
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd2, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_slave_error();
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd1, 1, 1'b1, 32'hCAFE_0001, 1, 1'b0);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'd0, 10, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        xfer(1'b1, 32'h0000_0084, 32'h0BAD_F00D, 4'h3, 3'd4, TO, 1'b1, 32'h0, 0, 1'b0);
        // pready in the last allowed ACCESS cycle completes normally
        xfer(1'b0, 32'h0000_0088, 32'h0, 4'h0, 3'd0, TO - 1, 1'b0, 32'h7777_1111, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        nx_write = 1'b1;
        nx_addr  = 32'h0000_0100;
        nx_wdata = 32'hA5A5_5A5A;
        nx_strb  = 4'h5;
        nx_prot  = 3'd7;
        xfer(1'b0, 32'h0000_00F0, 32'h0, 4'h0, 3'd3, 2, 1'b0, 32'h0102_0304, 5, 1'b1);
        xfer(nx_write, nx_addr, nx_wdata, nx_strb, nx_prot, 0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h0000_0200;
        req_strb_i  = 4'h0;
        req_prot_i  = 3'd1;
        step();
        req_valid_i = 1'b0;
        step();
        step();
        total++;
        if (penable_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_access: penable got %b want 1", penable_o);
        end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        total++;
        if ({psel_o, penable_o, rsp_valid_o, req_ready_o} !== 4'b0001 || paddr_o !== '0) begin
            bad++;
            $display("FAIL mid_reset: got sel/en/vld/rdy=%b paddr=%h want 0001 0",
                     {psel_o, penable_o, rsp_valid_o, req_ready_o}, paddr_o);
        end
        step();
        total++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL after_reset: got vld/rdy=%b want 01", {rsp_valid_o, req_ready_o});
        end
        xfer(1'b1, 32'h0000_0204, 32'h1357_9BDF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 6)), 1'($urandom), $urandom,
                 int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
